// File: rtl/cacheline_adaptor_if.sv
// rtl/cacheline_adaptor_if.sv - cache-side line and memory-side burst signals of the line adaptor
interface cacheline_adaptor_if;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cache line to four 64-bit memory bursts
// One request/response per line; all outputs are registered decodes of next state.
module cacheline_adaptor (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_adaptor_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [26:0]   addr_q, addr_d;
  logic [255:0]  line_q, line_d;
  logic [255:0]  fill_q, fill_d;
  logic [63:0]   burst_q, burst_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic          resp_q, resp_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (bus.read_i) begin
          addr_d  = bus.address_i[31:5];
          cnt_d   = 2'd0;
          state_d = READ;
        end else if (bus.write_i) begin
          addr_d  = bus.address_i[31:5];
          line_d  = bus.line_i;
          cnt_d   = 2'd0;
          state_d = WRITE;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          fill_d[{cnt_q, 6'b0} +: 64] = bus.burst_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = 2'd0;
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered with no resp_i path.
    read_d  = (state_d == READ);
    write_d = (state_d == WRITE);
    resp_d  = (state_d == DONE);
    burst_d = (state_d == WRITE) ? line_d[{cnt_d, 6'b0} +: 64] : 64'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 27'd0;
      line_q  <= 256'd0;
      fill_q  <= 256'd0;
      burst_q <= 64'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      fill_q  <= fill_d;
      burst_q <= burst_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.line_o    = fill_q;
  assign bus.address_o = {addr_q, 5'b0};
  assign bus.burst_o   = burst_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;

  // The cache must never request a read and a write-back in the same cycle.
  a_no_dual_request: assert property (@(posedge clk) disable iff (rst)
    !((state_q == IDLE) && bus.read_i && bus.write_i));

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;
  int   resp_cnt = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();
  cacheline_adaptor dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [255:0] L_RD1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] L_WR1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] L_RD2 = {64'h8888_0000_8888_0000, 64'h7777_0000_7777_0000,
                                    64'h6666_0000_6666_0000, 64'h5555_0000_5555_0000};
  localparam logic [255:0] L_WR2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                    64'h0F0F_0F0F_F0F0_F0F0, 64'h1357_9BDF_2468_ACE0};
  localparam logic [255:0] L_RD3 = {64'h9999_AAAA_BBBB_CCCC, 64'h1212_3434_5656_7878,
                                    64'hCAFE_F00D_CAFE_F00D, 64'hDEAD_BEEF_0000_0001};

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.resp_o === 1'b1) resp_cnt++;
  endtask

  task automatic run_read(input string tag, input logic [31:0] addr, input logic [255:0] line);
    int t0;
    int r0;
    r0 = resp_cnt;
    t0 = cyc;
    bus.address_i = addr;
    bus.read_i    = 1'b1;
    step;
    check_eq({tag, "_read_o"}, bus.read_o, 1);
    check_eq({tag, "_addr_o"}, bus.address_o, {addr[31:5], 5'b0});
    bus.address_i = ~addr;
    bus.resp_i    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.burst_i = line[64*i +: 64];
      step;
      if (i < 3) begin
        check_eq({tag, "_mid_resp_o"}, bus.resp_o, 0);
        check_eq({tag, "_mid_read_o"}, bus.read_o, 1);
      end
    end
    check_eq({tag, "_resp_o"}, bus.resp_o, 1);
    check_eq({tag, "_read_o_fall"}, bus.read_o, 0);
    check_eq({tag, "_line_o"}, bus.line_o, line);
    check_eq({tag, "_latency"}, cyc - t0, 5);
    check_eq({tag, "_addr_hold"}, bus.address_o, {addr[31:5], 5'b0});
    bus.read_i  = 1'b0;
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    step;
    check_eq({tag, "_resp_pulse"}, bus.resp_o, 0);
    check_eq({tag, "_resp_count"}, resp_cnt - r0, 1);
  endtask

  task automatic run_write(input string tag, input logic [31:0] addr, input logic [255:0] line,
                           input logic [15:0] pat, input int npat);
    int beat;
    int whi;
    int r0;
    r0   = resp_cnt;
    beat = 0;
    whi  = 0;
    bus.address_i = addr;
    bus.line_i    = line;
    bus.write_i   = 1'b1;
    step;
    if (bus.write_o === 1'b1) whi++;
    check_eq({tag, "_write_o"}, bus.write_o, 1);
    check_eq({tag, "_beat0"}, bus.burst_o, line[63:0]);
    check_eq({tag, "_addr_o"}, bus.address_o, {addr[31:5], 5'b0});
    bus.address_i = addr ^ 32'hFFFF_FFE0;
    bus.line_i    = ~line;
    for (int k = 0; k < npat; k++) begin
      bus.resp_i = pat[k];
      step;
      if (pat[k]) beat++;
      if (bus.write_o === 1'b1) whi++;
      if (beat < 4) begin
        check_eq({tag, "_burst_o"}, bus.burst_o, line[64*beat +: 64]);
        check_eq({tag, "_addr_iso"}, bus.address_o, {addr[31:5], 5'b0});
        check_eq({tag, "_mid_resp_o"}, bus.resp_o, 0);
      end
    end
    check_eq({tag, "_resp_o"}, bus.resp_o, 1);
    check_eq({tag, "_write_o_fall"}, bus.write_o, 0);
    check_eq({tag, "_write_cycles"}, whi, npat);
    bus.write_i = 1'b0;
    bus.resp_i  = 1'b0;
    step;
    check_eq({tag, "_resp_pulse"}, bus.resp_o, 0);
    check_eq({tag, "_resp_count"}, resp_cnt - r0, 1);
  endtask

  initial begin
    int r0;
    rst           = 1'b1;
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    step;
    step;
    check_eq("rst_resp_o", bus.resp_o, 0);
    check_eq("rst_read_o", bus.read_o, 0);
    check_eq("rst_write_o", bus.write_o, 0);
    check_eq("rst_address_o", bus.address_o, 0);
    check_eq("rst_burst_o", bus.burst_o, 0);
    check_eq("rst_line_o", bus.line_o, 0);
    rst = 1'b0;
    step;

    run_read("rd_nostall", 32'h0000_1234, L_RD1);
    run_write("wr_stall", 32'h0000_ABCD, L_WR1, 16'h0059, 7);

    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hDEAD_DEAD_DEAD_DEAD;
    for (int i = 0; i < 3; i++) begin
      step;
      check_eq("idle_read_o", bus.read_o, 0);
      check_eq("idle_write_o", bus.write_o, 0);
      check_eq("idle_resp_o", bus.resp_o, 0);
    end
    check_eq("idle_line_hold", bus.line_o, L_RD1);
    bus.resp_i = 1'b0;
    step;

    r0 = resp_cnt;
    bus.address_i = 32'h0000_2040;
    bus.read_i    = 1'b1;
    step;
    check_eq("b2b_read_o", bus.read_o, 1);
    bus.resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.burst_i = L_RD2[64*i +: 64];
      step;
    end
    check_eq("b2b_rd_resp", bus.resp_o, 1);
    bus.resp_i = 1'b0;
    step;
    check_eq("b2b_idle_resp_o", bus.resp_o, 0);
    check_eq("b2b_idle_read_o", bus.read_o, 0);
    check_eq("b2b_rd_line", bus.line_o, L_RD2);
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b1;
    bus.line_i    = L_WR2;
    bus.address_i = 32'h0000_4000;
    step;
    check_eq("b2b_write_o", bus.write_o, 1);
    check_eq("b2b_wr_addr", bus.address_o, 32'h0000_4000);
    bus.resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("b2b_wr_beat", bus.burst_o, L_WR2[64*i +: 64]);
      step;
    end
    check_eq("b2b_wr_resp", bus.resp_o, 1);
    bus.write_i = 1'b0;
    bus.resp_i  = 1'b0;
    step;
    check_eq("b2b_resp_count", resp_cnt - r0, 2);

    r0 = resp_cnt;
    bus.address_i = 32'h0000_3000;
    bus.read_i    = 1'b1;
    step;
    bus.resp_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.burst_i = 64'hABAB_ABAB_0000_0000 + 64'(i);
      step;
    end
    rst        = 1'b1;
    bus.resp_i = 1'b0;
    step;
    check_eq("mid_rst_read_o", bus.read_o, 0);
    check_eq("mid_rst_resp_o", bus.resp_o, 0);
    check_eq("mid_rst_line_o", bus.line_o, 0);
    check_eq("mid_rst_address_o", bus.address_o, 0);
    check_eq("mid_rst_no_resp", resp_cnt - r0, 0);
    rst = 1'b0;
    run_read("rd_after_rst", 32'h0000_3000, L_RD3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Bridges the cache's 256-bit line interface to the 64-bit burst memory interface. It is the memory-side end of the cache datapath's `address_to_mem` / `cacheline_data_out` / `data_from_mem` path. A line fill is gathered from four consecutive 64-bit beats into one 256-bit line. A line write-back is split into four 64-bit beats. The cache sees a single request/response handshake per line.

## Interface
- No parameters; line width 256, beat width 64 and 4 beats per line are fixed.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `line_i`  in  256  write-back line from cache (`cacheline_data_out`).
- `line_o`  out  256  filled line to cache (`data_from_mem`).
- `address_i`  in  32  line address from cache (`address_to_mem`).
- `read_i`  in  1  cache line-read request; held high until `resp_o`.
- `write_i`  in  1  cache line-write request; held high until `resp_o`.
- `resp_o`  out  1  one-cycle pulse: line transaction complete.
- `burst_i`  in  64  read beat from memory.
- `burst_o`  out  64  write beat to memory.
- `address_o`  out  32  memory address, `{addr_q[31:5], 5'b0}`.
- `read_o`  out  1  memory burst-read request.
- `write_o`  out  1  memory burst-write request.
- `resp_i`  in  1  memory beat valid/accepted, one per beat.

## Operation
- States: IDLE, READ, WRITE, DONE. There is a 2-bit beat counter `cnt`.
- IDLE:
  - `read_i`=1 → latch `address_i` into `addr_q`; `cnt`←0; go to READ.
  - Else `write_i`=1 → latch `address_i` and `line_i` into `line_q`; `cnt`←0; go to WRITE.
  - `read_i` and `write_i` both high → treated as a read; the write is ignored. This case is illegal from the cache and is flagged by an assertion.
- READ:
  - `read_o`=1.
  - On `resp_i`=1, write `burst_i` into `line_o[64*cnt +: 64]`, then `cnt`←`cnt`+1.
  - On the beat where `cnt`=3 with `resp_i`=1, go to DONE.
- WRITE:
  - `write_o`=1 and `burst_o`=`line_q[64*cnt +: 64]`.
  - On `resp_i`=1, `cnt`←`cnt`+1.
  - On `cnt`=3 with `resp_i`=1, go to DONE.
- DONE: `resp_o`=1 for exactly one cycle, then unconditionally go to IDLE. A request still high in that IDLE cycle starts a new transaction.
- Cycles with `resp_i`=0 in READ or WRITE are stalls: the counter holds and outputs hold. Gaps between beats are legal and of any length.
- `resp_i` is ignored in IDLE and DONE.
- Beat order is always 0,1,2,3 (low 64 bits first). `cnt` wraps to 0 only via the transition out of DONE/IDLE, never mid-burst.
- `address_o`, `line_q` and `addr_q` are stable from request acceptance to DONE. Changes on `address_i`/`line_i` after acceptance have no effect.
- `line_o` holds its last filled value until the next READ overwrites it beat by beat. It is valid in full when `resp_o`=1.

## Timing
- Reset values: state IDLE, `cnt`=0, `resp_o`=0, `read_o`=0, `write_o`=0, `address_o`=0, `burst_o`=0, `line_o`=0.
- `rst` mid-transaction aborts it. The next cycle is IDLE with all outputs at reset values, and no `resp_o` is produced for the aborted line.
- `read_o`/`write_o` rise the cycle after the request is sampled in IDLE.
- `read_o`/`write_o` fall the cycle after the 4th `resp_i`, i.e. in DONE.
- With zero-stall memory, latency is: request sampled at edge T → beats at T+1..T+4 → `resp_o` high in cycle T+5. The cache therefore sees `resp_o` 5 cycles after asserting its request.
- `read_o`, `write_o`, `resp_o` and `burst_o` are registered-state decodes only; there is no combinational path from `resp_i` to any output.

## Test plan
- Read fill, no stalls:
  - Stimulus: `address_i`=0x0000_1234, `read_i`=1; memory returns beats 0x1111…, 0x2222…, 0x3333…, 0x4444… on 4 consecutive cycles.
  - Response: `address_o`=0x0000_1220; `line_o`={0x4444…,0x3333…,0x2222…,0x1111…}; `resp_o` pulses once at T+5.
- Write-back with stalls:
  - Stimulus: `line_i`=256'h…DDDD_CCCC_BBBB_AAAA pattern per beat, `write_i`=1; `resp_i` pattern 1,0,0,1,1,0,1.
  - Response: `burst_o` steps beat0→beat3 only on `resp_i`; `write_o` high for 7 cycles; one `resp_o`.
- Back-to-back:
  - Stimulus: the cache holds `read_i` through DONE, then issues a write.
  - Response: exactly one `resp_o` per transaction; the second transaction starts in the IDLE cycle after DONE.
- Reset mid-burst:
  - Stimulus: assert `rst` after 2 read beats.
  - Response: next cycle `read_o`=0, `resp_o`=0, `line_o`=0; a new read then completes normally.
- Input isolation:
  - Stimulus: change `address_i`/`line_i` during WRITE; pulse `resp_i` while IDLE.
  - Response: `address_o`/`burst_o` are unaffected; no state change in IDLE.
